// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered arithmetic/logic unit for the execute stage.
//
// The operation is chosen by `control`; when `control` selects an A-type
// instruction, `funct_code` chooses the operation. The result and a zero flag
// are registered on the rising edge of clk. There is one cycle of latency and
// no handshake, so a new operation is accepted every cycle.
//
// Ports:
//   op1        in  WIDTH  first operand (A)
//   op2        in  WIDTH  second operand (B); also the shift/rotate amount
//   funct_code in  4      A-type function select (used only when control=00)
//   control    in  2      operation class from the control unit
//   clk        in  1      system clock, rising edge
//   result     out WIDTH  registered result
//   zero       out 1      registered flag, 1 when result is all zeros
//   rst        in  1      synchronous active-high reset (result=0, zero=1)
//
// The port order is kept as-is so that existing positional instantiations
// still connect correctly.
// ---------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       funct_code,
    input  logic [1:0]       control,
    input  logic             clk,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic             rst
);

    // Width of a shift/rotate amount that stays inside the operand.
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        CTRL_ATYPE = 2'b00,
        CTRL_ADD   = 2'b01,
        CTRL_SUB   = 2'b10,
        CTRL_PASS  = 2'b11
    } ctrl_e;

    typedef enum logic [3:0] {
        FN_MUL = 4'b0001,
        FN_DIV = 4'b0010,
        FN_ROL = 4'b1000,
        FN_ROR = 4'b1001,
        FN_LSL = 4'b1010,
        FN_LSR = 4'b1011,
        FN_OR  = 4'b1100,
        FN_AND = 4'b1101,
        FN_SUB = 4'b1110,
        FN_ADD = 4'b1111
    } funct_e;

    logic [SHW-1:0]     amt;         // in-range part of the shift amount
    logic               shift_big;   // op2 >= WIDTH: logical shifts flush to 0
    logic [2*WIDTH-1:0] rol_wide;
    logic [2*WIDTH-1:0] ror_wide;
    logic [WIDTH-1:0]   atype_result;
    logic [WIDTH-1:0]   next_result;

    assign amt       = op2[SHW-1:0];
    assign shift_big = |op2[WIDTH-1:SHW];

    // Rotates shift a doubled copy of the operand. The bits that fall out of
    // one half reappear in the other half. Rotates use only the low SHW bits
    // of op2, so a rotate by WIDTH+n behaves like a rotate by n.
    assign rol_wide = {op1, op1} << amt;
    assign ror_wide = {op1, op1} >> amt;

    always_comb begin
        // NOTE: assign a default first so that every path of the case drives
        // the output. Any path left undriven would infer a latch.
        atype_result = '0;
        case (funct_code)
            FN_ADD: atype_result = op1 + op2;
            FN_SUB: atype_result = op1 - op2;
            FN_AND: atype_result = op1 & op2;
            FN_OR:  atype_result = op1 | op2;
            FN_MUL: atype_result = op1 * op2;   // low WIDTH bits of the product
            FN_DIV: atype_result = (op2 == '0) ? '1 : (op1 / op2);
            FN_LSL: atype_result = shift_big ? '0 : (op1 << amt);
            FN_LSR: atype_result = shift_big ? '0 : (op1 >> amt);
            FN_ROL: atype_result = rol_wide[2*WIDTH-1:WIDTH];
            FN_ROR: atype_result = ror_wide[WIDTH-1:0];
            default: atype_result = '0;
        endcase
    end

    always_comb begin
        next_result = '0;
        case (control)
            CTRL_ATYPE: next_result = atype_result;
            CTRL_ADD:   next_result = op1 + op2;
            CTRL_SUB:   next_result = op1 - op2;
            CTRL_PASS:  next_result = op2;
            default:    next_result = '0;
        endcase
    end

    // The zero flag comes from the same next value as the result, so both
    // registers always agree with each other.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments. Each register then
        // samples the values from before the edge, so the result does not
        // depend on the order of the statements.
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= next_result;
            zero   <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// A table of {inputs, expected outputs} records is applied one per clock.
// When a record's stimulus is driven, its expected result is pushed onto a
// scoreboard queue. The entry is popped and compared after the edge that
// registers that stimulus. Hand-written sequences cover the following:
//   - a back-to-back stream of adds with a reset asserted in the middle;
//   - output hold between clock edges.
// ---------------------------------------------------------------------------
module tb_alu;

    typedef struct packed {
        logic       rst;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [3:0] funct;
        logic [1:0] control;
        logic [7:0] exp_result;
        logic       exp_zero;
    } vec_t;

    typedef struct packed {
        logic [7:0] result;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [3:0] funct_code;
    logic [1:0] control;
    logic [7:0] result;
    logic       zero;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[$];
    exp_t last_exp;

    alu #(.WIDTH(8)) dut (
        .op1        (op1),
        .op2        (op2),
        .funct_code (funct_code),
        .control    (control),
        .clk        (clk),
        .result     (result),
        .zero       (zero),
        .rst        (rst)
    );

    always #5 clk = ~clk;

    // Stops the run if it ever stops making progress.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] f, input logic [1:0] c,
                                input logic [7:0] er, input logic ez);
        vec_t v;
        v.rst = r; v.op1 = a; v.op2 = b; v.funct = f; v.control = c;
        v.exp_result = er; v.exp_zero = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act_r, input logic act_z,
                         input logic [7:0] exp_r, input logic exp_z);
        n_cmp++;
        if (act_r !== exp_r || act_z !== exp_z) begin
            n_fail++;
            $display("FAIL %s: got result=%h zero=%b, want result=%h zero=%b",
                     name, act_r, act_z, exp_r, exp_z);
        end
    endtask

    // The drive happens at the falling edge, away from the sampling edge.
    task automatic drive(input vec_t v);
        @(negedge clk);
        // NOTE: the bench drives inputs with blocking assignments from
        // procedural code. The DUT registers sample them at the next rising
        // edge.
        rst        = v.rst;
        op1        = v.op1;
        op2        = v.op2;
        funct_code = v.funct;
        control    = v.control;
        sb_q.push_back({v.exp_result, v.exp_zero});
    endtask

    // Runs one edge, then compares the DUT outputs with the oldest
    // scoreboard entry.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        drive(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got result=%h, want an entry", name, result);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            check(name, result, zero, e.result, e.zero);
        end
    endtask

    initial begin
        rst = 1'b1; op1 = 8'hA5; op2 = 8'h3C; funct_code = 4'hF; control = 2'b00;

        // rst, op1, op2, funct, control, expected result, expected zero
        vecs.push_back(mk(1'b1, 8'hA5, 8'h3C, 4'hF, 2'b00, 8'h00, 1'b1)); // reset wins
        vecs.push_back(mk(1'b0, 8'h00, 8'h00, 4'h0, 2'b00, 8'h00, 1'b1)); // undefined code
        // A-type sweep with op1=0x08, op2=0x01
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hF, 2'b00, 8'h09, 1'b0)); // add
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hE, 2'b00, 8'h07, 1'b0)); // sub
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hD, 2'b00, 8'h00, 1'b1)); // and
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hC, 2'b00, 8'h09, 1'b0)); // or
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h1, 2'b00, 8'h08, 1'b0)); // mul
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h2, 2'b00, 8'h08, 1'b0)); // div
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hA, 2'b00, 8'h10, 1'b0)); // lsl
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'hB, 2'b00, 8'h04, 1'b0)); // lsr
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h8, 2'b00, 8'h10, 1'b0)); // rol
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h9, 2'b00, 8'h04, 1'b0)); // ror
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h3, 2'b00, 8'h00, 1'b1)); // undefined
        vecs.push_back(mk(1'b0, 8'h08, 8'h01, 4'h7, 2'b00, 8'h00, 1'b1)); // undefined
        // wrap and boundaries
        vecs.push_back(mk(1'b0, 8'h00, 8'h01, 4'hE, 2'b00, 8'hFF, 1'b0)); // sub wrap
        vecs.push_back(mk(1'b0, 8'hFF, 8'h01, 4'hF, 2'b00, 8'h00, 1'b1)); // add wrap
        vecs.push_back(mk(1'b0, 8'h10, 8'h10, 4'h1, 2'b00, 8'h00, 1'b1)); // mul overflow
        vecs.push_back(mk(1'b0, 8'h0F, 8'h11, 4'h1, 2'b00, 8'hFF, 1'b0)); // mul 0x0F*0x11
        vecs.push_back(mk(1'b0, 8'h08, 8'h00, 4'h2, 2'b00, 8'hFF, 1'b0)); // div by zero
        vecs.push_back(mk(1'b0, 8'hFF, 8'h10, 4'h2, 2'b00, 8'h0F, 1'b0)); // div 255/16
        // shift / rotate edges
        vecs.push_back(mk(1'b0, 8'h81, 8'h01, 4'h8, 2'b00, 8'h03, 1'b0)); // rol 1
        vecs.push_back(mk(1'b0, 8'h81, 8'h01, 4'h9, 2'b00, 8'hC0, 1'b0)); // ror 1
        vecs.push_back(mk(1'b0, 8'h81, 8'h08, 4'hA, 2'b00, 8'h00, 1'b1)); // lsl 8
        vecs.push_back(mk(1'b0, 8'h81, 8'h09, 4'h8, 2'b00, 8'h03, 1'b0)); // rol 9 == rol 1
        vecs.push_back(mk(1'b0, 8'h81, 8'h09, 4'h9, 2'b00, 8'hC0, 1'b0)); // ror 9 == ror 1
        vecs.push_back(mk(1'b0, 8'h81, 8'h07, 4'h8, 2'b00, 8'hC0, 1'b0)); // rol 7
        vecs.push_back(mk(1'b0, 8'h81, 8'h07, 4'hA, 2'b00, 8'h80, 1'b0)); // lsl 7
        vecs.push_back(mk(1'b0, 8'h81, 8'h07, 4'hB, 2'b00, 8'h01, 1'b0)); // lsr 7
        vecs.push_back(mk(1'b0, 8'h81, 8'h08, 4'hB, 2'b00, 8'h00, 1'b1)); // lsr 8
        vecs.push_back(mk(1'b0, 8'h81, 8'h10, 4'hB, 2'b00, 8'h00, 1'b1)); // lsr 16
        vecs.push_back(mk(1'b0, 8'h81, 8'h10, 4'hA, 2'b00, 8'h00, 1'b1)); // lsl 16
        // control classes; funct_code is set to arbitrary values and ignored
        vecs.push_back(mk(1'b0, 8'h05, 8'h05, 4'hD, 2'b01, 8'h0A, 1'b0)); // add
        vecs.push_back(mk(1'b0, 8'h05, 8'h05, 4'h2, 2'b10, 8'h00, 1'b1)); // sub equal
        vecs.push_back(mk(1'b0, 8'h05, 8'h05, 4'h1, 2'b11, 8'h05, 1'b0)); // pass op2
        vecs.push_back(mk(1'b0, 8'h03, 8'h05, 4'hF, 2'b10, 8'hFE, 1'b0)); // sub wrap
        vecs.push_back(mk(1'b0, 8'hC3, 8'h00, 4'hF, 2'b11, 8'h00, 1'b1)); // pass zero

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // Mid-stream reset inside back-to-back adds. The edge after the reset
        // resumes normal results.
        step(mk(1'b0, 8'h01, 8'h01, 4'hF, 2'b00, 8'h02, 1'b0), "stream_add0");
        step(mk(1'b0, 8'h02, 8'h03, 4'hF, 2'b00, 8'h05, 1'b0), "stream_add1");
        step(mk(1'b1, 8'h10, 8'h10, 4'hF, 2'b00, 8'h00, 1'b1), "stream_reset");
        step(mk(1'b0, 8'h04, 8'h04, 4'hF, 2'b00, 8'h08, 1'b0), "stream_resume");
        step(mk(1'b0, 8'h20, 8'h01, 4'h0, 2'b01, 8'h21, 1'b0), "stream_ctrl_add");

        // Hold: change the inputs well before the next rising edge. The
        // registered outputs must keep the last expected value.
        @(negedge clk);
        rst = 1'b0; op1 = 8'h7E; op2 = 8'h11; funct_code = 4'hC; control = 2'b00;
        #2;
        check("hold", result, zero, last_exp.result, last_exp.zero);
        step(mk(1'b0, 8'h7E, 8'h11, 4'hC, 2'b00, 8'h7F, 1'b0), "after_hold");

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
